// File: rtl/mul_div_unit_pkg.sv
// Shared MDU definitions: operation codes, FSM state encodings, step count and operand helper.
// Imported by the multiply/divide unit, its interface users and the bench.
package mul_div_unit_pkg;

  localparam logic [2:0] MDUOP_MULT  = 3'd1;
  localparam logic [2:0] MDUOP_MULTU = 3'd2;
  localparam logic [2:0] MDUOP_DIV   = 3'd3;
  localparam logic [2:0] MDUOP_DIVU  = 3'd4;
  localparam logic [2:0] MDUOP_MTHI  = 3'd5;
  localparam logic [2:0] MDUOP_MTLO  = 3'd6;

  localparam int MDU_CYCLES = 32;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PREP = 2'd1,
    ST_CALC = 2'd2,
    ST_FIX  = 2'd3
  } mdu_state_e;

  function automatic logic [31:0] mag32(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// Execute-stage <-> multiply/divide unit bundle: request, operands, status and HI/LO.
interface mul_div_unit_if;
  logic        start;
  logic [2:0]  MDU_control;
  logic        cancel;
  logic [31:0] src0;
  logic [31:0] src1;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, MDU_control, cancel, src0, src1,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, MDU_control, cancel, src0, src1,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mul_div_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU with HI/LO registers; one shift-add or restoring shift-subtract step per cycle.
// Latency 34 cycles from accepted start to HI/LO update; MTHI/MTLO write HI/LO at the sampling edge.
module mul_div_unit (
  input  logic             clk,
  input  logic             reset,
  mul_div_unit_if.slave    mdu
);
  import mul_div_unit_pkg::*;

  mdu_state_e  state;
  logic [4:0]  count;
  logic [63:0] work;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic        is_div;
  logic        is_signed;
  logic        neg_lo;
  logic        neg_hi;
  logic        dz;
  logic        busy_q;
  logic        done_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;

  logic        op_md;
  logic        op_div;
  logic        op_signed;
  logic        a_neg;
  logic        b_neg;
  logic [32:0] rem33;
  logic        ge;
  logic [31:0] sub32;
  logic [32:0] sum33;
  logic [63:0] step;
  logic [63:0] prod;
  logic [31:0] quo;
  logic [31:0] rmd;
  logic [31:0] res_hi;
  logic [31:0] res_lo;

  always_comb begin
    op_md     = (mdu.MDU_control == MDUOP_MULT) || (mdu.MDU_control == MDUOP_MULTU) ||
                (mdu.MDU_control == MDUOP_DIV)  || (mdu.MDU_control == MDUOP_DIVU);
    op_div    = (mdu.MDU_control == MDUOP_DIV)  || (mdu.MDU_control == MDUOP_DIVU);
    op_signed = (mdu.MDU_control == MDUOP_MULT) || (mdu.MDU_control == MDUOP_DIV);
    a_neg     = is_signed & a_q[31];
    b_neg     = is_signed & b_q[31];

    // Partial remainder can reach 33 bits after the shift; when it is >= divisor the
    // difference always fits in 32 bits, so the low-word subtract is exact.
    rem33 = work[63:31];
    ge    = rem33 >= {1'b0, b_q};
    sub32 = rem33[31:0] - b_q;
    sum33 = {1'b0, work[63:32]} + {1'b0, b_q};

    step = '0;
    if (is_div)
      step = ge ? {sub32, work[30:0], 1'b1} : {work[62:0], 1'b0};
    else
      step = work[0] ? {sum33, work[31:1]} : {1'b0, work[63:1]};

    prod = neg_lo ? -work : work;
    quo  = neg_lo ? -work[31:0] : work[31:0];
    rmd  = neg_hi ? -work[63:32] : work[63:32];

    res_hi = prod[63:32];
    res_lo = prod[31:0];
    if (is_div) begin
      res_hi = dz ? a_q : rmd;
      res_lo = dz ? 32'hFFFF_FFFF : quo;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      count     <= '0;
      work      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      is_div    <= 1'b0;
      is_signed <= 1'b0;
      neg_lo    <= 1'b0;
      neg_hi    <= 1'b0;
      dz        <= 1'b0;
      busy_q    <= DISABLE;
      done_q    <= DISABLE;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      done_q <= DISABLE;
      if (state != ST_IDLE && mdu.cancel) begin
        state  <= ST_IDLE;
        count  <= '0;
        busy_q <= DISABLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (mdu.start && !mdu.cancel) begin
              if (op_md) begin
                state     <= ST_PREP;
                busy_q    <= ENABLE;
                a_q       <= mdu.src0;
                b_q       <= mdu.src1;
                is_div    <= op_div;
                is_signed <= op_signed;
              end else if (mdu.MDU_control == MDUOP_MTHI) begin
                hi_q <= mdu.src0;
              end else if (mdu.MDU_control == MDUOP_MTLO) begin
                lo_q <= mdu.src0;
              end
            end
          end
          ST_PREP: begin
            // a_q stays raw: a zero divisor returns the dividend as latched.
            neg_lo <= a_neg ^ b_neg;
            neg_hi <= a_neg;
            dz     <= (b_q == 32'd0);
            b_q    <= mag32(b_q, b_neg);
            work   <= {32'd0, mag32(a_q, a_neg)};
            count  <= '0;
            state  <= ST_CALC;
          end
          ST_CALC: begin
            work  <= step;
            count <= count + 5'd1;
            if (count == 5'(MDU_CYCLES - 1))
              state <= ST_FIX;
          end
          ST_FIX: begin
            hi_q   <= res_hi;
            lo_q   <= res_lo;
            done_q <= ENABLE;
            busy_q <= DISABLE;
            state  <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign mdu.busy = busy_q;
  assign mdu.done = done_q;
  assign mdu.hi   = hi_q;
  assign mdu.lo   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Bench for mul_div_unit: scoreboarded MULT/DIV results, MTHI/MTLO, cancel, back-to-back and mid-op reset.
module tb_mul_div_unit;
  import mul_div_unit_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   cmp_cnt = 0;
  int   err_cnt = 0;
  logic [63:0] sb_q[$];
  logic [63:0] last_res = '0;

  mul_div_unit_if mdu();

  mul_div_unit dut (
    .clk   (clk),
    .reset (reset),
    .mdu   (mdu)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] res;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    res = '0;
    case (op)
      MDUOP_MULT:  res = 64'(sa * sb);
      MDUOP_MULTU: res = {32'd0, a} * {32'd0, b};
      MDUOP_DIV: begin
        if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          res = {r[31:0], q[31:0]};
        end
      end
      MDUOP_DIVU: begin
        if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
        else res = {a % b, a / b};
      end
      default: res = '0;
    endcase
    return res;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input bit track);
    mdu.start = 1'b1;
    mdu.MDU_control = op;
    mdu.src0 = a;
    mdu.src1 = b;
    if (track) sb_q.push_back(model(op, a, b));
    tick();
    mdu.start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (mdu.done === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    tick();
    tick();
    cmp_cnt++; if (mdu.busy !== 1'b0) begin err_cnt++; $display("FAIL reset_busy got %b want 0", mdu.busy); end
    cmp_cnt++; if (mdu.done !== 1'b0) begin err_cnt++; $display("FAIL reset_done got %b want 0", mdu.done); end
    cmp_cnt++; if (mdu.hi !== 32'd0) begin err_cnt++; $display("FAIL reset_hi got %h want 0", mdu.hi); end
    cmp_cnt++; if (mdu.lo !== 32'd0) begin err_cnt++; $display("FAIL reset_lo got %h want 0", mdu.lo); end
    @(negedge clk);
    reset = 1'b1;
    tick();
  endtask

  task automatic run_table(input string name, input logic [2:0] ops[8], input logic [31:0] as[8], input logic [31:0] bs[8]);
    int lat;
    logic [63:0] exp;
    for (int i = 0; i < 8; i++) begin
      start_op(ops[i], as[i], bs[i], 1'b1);
      cmp_cnt++; if (mdu.busy !== 1'b1) begin err_cnt++; $display("FAIL %s[%0d]_busy_on got %b want 1", name, i, mdu.busy); end
      wait_done(lat);
      exp = sb_q.pop_front();
      last_res = exp;
      cmp_cnt++; if (lat !== 34) begin err_cnt++; $display("FAIL %s[%0d]_latency got %0d want 34", name, i, lat); end
      cmp_cnt++; if ({mdu.hi, mdu.lo} !== exp) begin err_cnt++; $display("FAIL %s[%0d]_result got %h_%h want %h", name, i, mdu.hi, mdu.lo, exp); end
      cmp_cnt++; if (mdu.busy !== 1'b0) begin err_cnt++; $display("FAIL %s[%0d]_busy_off got %b want 0", name, i, mdu.busy); end
      tick();
      cmp_cnt++; if (mdu.done !== 1'b0) begin err_cnt++; $display("FAIL %s[%0d]_done_width got %b want 0", name, i, mdu.done); end
    end
  endtask

  task automatic test_mul();
    logic [2:0]  ops[8];
    logic [31:0] as[8];
    logic [31:0] bs[8];
    ops = '{MDUOP_MULTU, MDUOP_MULT, MDUOP_MULT, MDUOP_MULTU, MDUOP_MULT, MDUOP_MULT, MDUOP_MULTU, MDUOP_MULT};
    as  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 32'h7FFF_FFFF, $urandom, $urandom, $urandom};
    bs  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'h1234_5678, 32'h8000_0000, $urandom, $urandom, $urandom};
    run_table("mul", ops, as, bs);
  endtask

  task automatic test_div();
    logic [2:0]  ops[8];
    logic [31:0] as[8];
    logic [31:0] bs[8];
    ops = '{MDUOP_DIV, MDUOP_DIVU, MDUOP_DIV, MDUOP_DIVU, MDUOP_DIV, MDUOP_DIV, MDUOP_DIV, MDUOP_DIVU};
    as  = '{32'hFFFF_FFF9, 32'd100, 32'h8000_0000, 32'd5, 32'hFFFF_FFF7, 32'd7, $urandom, $urandom};
    bs  = '{32'd2, 32'd7, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'hFFFF_FFFE, $urandom_range(1, 32'hFFFF), $urandom_range(1, 32'hFFFF_FFFF)};
    run_table("div", ops, as, bs);
  endtask

  task automatic test_mt();
    int lat;
    logic [63:0] exp;
    start_op(MDUOP_MTLO, 32'hCAFE_F00D, 32'd0, 1'b0);
    cmp_cnt++; if (mdu.lo !== 32'hCAFE_F00D) begin err_cnt++; $display("FAIL mtlo_lo got %h want cafef00d", mdu.lo); end
    cmp_cnt++; if (mdu.done !== 1'b0 || mdu.busy !== 1'b0) begin err_cnt++; $display("FAIL mtlo_status got done=%b busy=%b want 0/0", mdu.done, mdu.busy); end
    start_op(MDUOP_MTHI, 32'h0BAD_BEEF, 32'd0, 1'b0);
    cmp_cnt++; if (mdu.hi !== 32'h0BAD_BEEF) begin err_cnt++; $display("FAIL mthi_hi got %h want 0badbeef", mdu.hi); end
    start_op(3'd7, 32'h5555_5555, 32'd0, 1'b0);
    cmp_cnt++; if ({mdu.hi, mdu.lo} !== 64'h0BAD_BEEF_CAFE_F00D || mdu.busy !== 1'b0) begin err_cnt++; $display("FAIL badop got %h_%h busy=%b want 0badbeef_cafef00d busy=0", mdu.hi, mdu.lo, mdu.busy); end
    mdu.cancel = 1'b1;
    start_op(MDUOP_MTHI, 32'h1111_1111, 32'd0, 1'b0);
    start_op(MDUOP_MULTU, 32'd3, 32'd3, 1'b0);
    mdu.cancel = 1'b0;
    cmp_cnt++; if (mdu.hi !== 32'h0BAD_BEEF || mdu.busy !== 1'b0) begin err_cnt++; $display("FAIL cancel_start got hi=%h busy=%b want 0badbeef busy=0", mdu.hi, mdu.busy); end
    start_op(MDUOP_DIVU, 32'd100, 32'd7, 1'b1);
    start_op(MDUOP_MTHI, 32'h1234_5678, 32'd0, 1'b0);
    cmp_cnt++; if (mdu.hi !== 32'h0BAD_BEEF) begin err_cnt++; $display("FAIL mthi_busy got %h want 0badbeef", mdu.hi); end
    wait_done(lat);
    exp = sb_q.pop_front();
    last_res = exp;
    cmp_cnt++; if (lat !== 33) begin err_cnt++; $display("FAIL mthi_busy_latency got %0d want 33", lat); end
    cmp_cnt++; if ({mdu.hi, mdu.lo} !== exp) begin err_cnt++; $display("FAIL mthi_busy_result got %h_%h want %h", mdu.hi, mdu.lo, exp); end
  endtask

  task automatic test_cancel();
    int pulses;
    start_op(MDUOP_MULTU, 32'hDEAD, 32'hBEEF, 1'b0);
    repeat (11) tick();
    cmp_cnt++; if (mdu.busy !== 1'b1) begin err_cnt++; $display("FAIL cancel_pre_busy got %b want 1", mdu.busy); end
    mdu.cancel = 1'b1;
    tick();
    mdu.cancel = 1'b0;
    cmp_cnt++; if (mdu.busy !== 1'b0) begin err_cnt++; $display("FAIL cancel_busy got %b want 0", mdu.busy); end
    pulses = 0;
    for (int k = 0; k < 30; k++) begin
      if (mdu.done === 1'b1) pulses++;
      tick();
    end
    cmp_cnt++; if (pulses !== 0) begin err_cnt++; $display("FAIL cancel_done got %0d pulses want 0", pulses); end
    cmp_cnt++; if ({mdu.hi, mdu.lo} !== last_res) begin err_cnt++; $display("FAIL cancel_hilo got %h_%h want %h", mdu.hi, mdu.lo, last_res); end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [63:0] exp;
    start_op(MDUOP_MULTU, 32'h0001_0001, 32'h0000_FFFF, 1'b1);
    wait_done(lat);
    exp = sb_q.pop_front();
    cmp_cnt++; if ({mdu.hi, mdu.lo} !== exp) begin err_cnt++; $display("FAIL b2b_first got %h_%h want %h", mdu.hi, mdu.lo, exp); end
    start_op(MDUOP_MULTU, 32'hABCD_1234, 32'h9876_5432, 1'b1);
    cmp_cnt++; if (mdu.busy !== 1'b1) begin err_cnt++; $display("FAIL b2b_accept got busy=%b want 1", mdu.busy); end
    wait_done(lat);
    exp = sb_q.pop_front();
    last_res = exp;
    cmp_cnt++; if (lat !== 34) begin err_cnt++; $display("FAIL b2b_latency got %0d want 34", lat); end
    cmp_cnt++; if ({mdu.hi, mdu.lo} !== exp) begin err_cnt++; $display("FAIL b2b_second got %h_%h want %h", mdu.hi, mdu.lo, exp); end
  endtask

  task automatic test_reset_mid();
    int lat;
    logic [63:0] exp;
    start_op(MDUOP_MULT, 32'h0000_1234, 32'hFFFF_FFFD, 1'b0);
    repeat (21) tick();
    #2 reset = 1'b0;
    #1;
    cmp_cnt++; if (mdu.busy !== 1'b0 || mdu.done !== 1'b0) begin err_cnt++; $display("FAIL midreset_status got busy=%b done=%b want 0/0", mdu.busy, mdu.done); end
    cmp_cnt++; if ({mdu.hi, mdu.lo} !== 64'd0) begin err_cnt++; $display("FAIL midreset_hilo got %h_%h want 0", mdu.hi, mdu.lo); end
    @(negedge clk);
    reset = 1'b1;
    tick();
    start_op(MDUOP_MULT, 32'hFFFF_FFFD, 32'd7, 1'b1);
    wait_done(lat);
    exp = sb_q.pop_front();
    cmp_cnt++; if (lat !== 34) begin err_cnt++; $display("FAIL postreset_latency got %0d want 34", lat); end
    cmp_cnt++; if ({mdu.hi, mdu.lo} !== exp) begin err_cnt++; $display("FAIL postreset_result got %h_%h want %h", mdu.hi, mdu.lo, exp); end
  endtask

  initial begin
    mdu.start = 1'b0;
    mdu.MDU_control = 3'd0;
    mdu.cancel = 1'b0;
    mdu.src0 = '0;
    mdu.src1 = '0;
    test_reset();
    test_mul();
    test_div();
    test_mt();
    test_cancel();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
